// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the bus-side memory responder: FSM states, strobe bundle, widths.
// Also provides the state-to-strobe decode used for the registered pin drivers.
package slc3_bus_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } mem_state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } mem_strobe_t;

    localparam mem_strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

    // Unreachable encodings fall into the default and park the pins inactive.
    function automatic mem_strobe_t strobe_for(input mem_state_t s);
        mem_strobe_t st;
        st = STROBE_IDLE;
        case (s)
            ST_RD:                   st = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
            ST_WR_SETUP, ST_WR_HOLD: st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1};
            ST_WR_PULSE:             st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
            default:                 st = STROBE_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing read wait states and write pulse width.
// Load takes priority; decrement saturates at zero.
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - {{(W-1){1'b0}}, 1'b1};
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bus_mem_responder.sv
// Bus-side MAR/MDR register pair plus the async SRAM access sequencer.
// Strobes, Busy, Done and Err are all registered from the next-state decode.
module bus_mem_responder #(
    parameter int DATA_W   = slc3_bus_pkg::DATA_W,
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] Bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Req_rd,
    input  logic              Req_wr,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic              Mem_CE_n,
    output logic              Mem_OE_n,
    output logic              Mem_WE_n
);

    import slc3_bus_pkg::*;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

    mem_state_t        state, state_n;
    mem_strobe_t       strb;
    logic [DATA_W-1:0] mar_n, mdr_n;
    logic              done_n, err_n;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              any_in;

    mem_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign any_in = LD_MAR | LD_MDR | Req_rd | Req_wr;

    always_comb begin
        state_n  = state;
        mar_n    = MAR;
        mdr_n    = MDR;
        done_n   = 1'b0;
        err_n    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = RD_LOAD;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (LD_MAR) mar_n = Bus;
                if (LD_MDR) mdr_n = Bus;
                if (Req_rd) begin
                    state_n  = ST_RD;
                    cnt_load = 1'b1;
                    cnt_val  = RD_LOAD;
                    err_n    = Req_wr;
                end else if (Req_wr) begin
                    state_n = ST_WR_SETUP;
                end
            end
            ST_RD: begin
                err_n = any_in;
                if (cnt_zero) begin
                    mdr_n   = Mem_rdata;
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_SETUP: begin
                err_n    = any_in;
                state_n  = ST_WR_PULSE;
                cnt_load = 1'b1;
                cnt_val  = WR_LOAD;
            end
            ST_WR_PULSE: begin
                err_n = any_in;
                if (cnt_zero) state_n = ST_WR_HOLD;
                else          cnt_dec = 1'b1;
            end
            ST_WR_HOLD: begin
                err_n   = any_in;
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            MAR   <= '0;
            MDR   <= '0;
            strb  <= STROBE_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_n;
            MAR   <= mar_n;
            MDR   <= mdr_n;
            strb  <= strobe_for(state_n);
            Busy  <= (state_n != ST_IDLE);
            Done  <= done_n;
            Err   <= err_n;
        end
    end

    assign Mem_addr  = MAR;
    assign Mem_wdata = MDR;
    assign Mem_CE_n  = strb.ce_n;
    assign Mem_OE_n  = strb.oe_n;
    assign Mem_WE_n  = strb.we_n;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: reset, read, write, collisions, async reset, back-to-back.
module tb_bus_mem_responder;

    logic        Clk, Reset_n;
    logic [15:0] Bus, MAR, MDR, Mem_addr, Mem_wdata, Mem_rdata;
    logic        LD_MAR, LD_MDR, Req_rd, Req_wr;
    logic        Busy, Done, Err, Mem_CE_n, Mem_OE_n, Mem_WE_n;

    int tests = 0;
    int fails = 0;

    bus_mem_responder #(.DATA_W(16), .RD_WAIT(2), .WR_PULSE(2)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Bus       (Bus),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .Req_rd    (Req_rd),
        .Req_wr    (Req_wr),
        .MAR       (MAR),
        .MDR       (MDR),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Mem_addr  (Mem_addr),
        .Mem_wdata (Mem_wdata),
        .Mem_rdata (Mem_rdata),
        .Mem_CE_n  (Mem_CE_n),
        .Mem_OE_n  (Mem_OE_n),
        .Mem_WE_n  (Mem_WE_n)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled at the following edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_in();
        LD_MAR = 1'b0; LD_MDR = 1'b0; Req_rd = 1'b0; Req_wr = 1'b0;
    endtask

    // 4-bit pattern {ce_n, oe_n, we_n, busy}
    function automatic logic [3:0] pins();
        return {Mem_CE_n, Mem_OE_n, Mem_WE_n, Busy};
    endfunction

    initial begin
        logic [3:0] wr_exp [4];
        wr_exp[0] = 4'b0111; wr_exp[1] = 4'b0101; wr_exp[2] = 4'b0101; wr_exp[3] = 4'b0111;

        Reset_n = 1'b0; Bus = '0; Mem_rdata = '0;
        clr_in();
        repeat (3) step();
        chk("rst_mar", MAR, 16'h0);
        chk("rst_mdr", MDR, 16'h0);
        chk("rst_pins", pins(), 4'b1110);
        chk("rst_done_err", {Done, Err}, 2'b00);
        Reset_n = 1'b1;
        step();

        // Read with same-cycle MAR load
        Bus = 16'h3000; LD_MAR = 1'b1; Req_rd = 1'b1; Mem_rdata = 16'hBEEF;
        step();
        clr_in(); Bus = '0;
        chk("rd_c1_pins", pins(), 4'b0011);
        chk("rd_addr", Mem_addr, 16'h3000);
        step();
        chk("rd_c2_pins", pins(), 4'b0011);
        step();
        chk("rd_done_pins", pins(), 4'b1110);
        chk("rd_done", {Done, Err}, 2'b10);
        chk("rd_mdr", MDR, 16'hBEEF);

        // Back-to-back write requested on the read's Done cycle
        Req_wr = 1'b1;
        step();
        clr_in();
        chk("b2b_setup_pins", pins(), 4'b0111);
        chk("b2b_wdata", Mem_wdata, 16'hBEEF);
        repeat (4) step();
        chk("b2b_done", Done, 1'b1);

        // Directed write
        Bus = 16'h0040; LD_MAR = 1'b1;
        step();
        clr_in(); Bus = 16'h1234; LD_MDR = 1'b1;
        step();
        clr_in(); Bus = '0; Req_wr = 1'b1;
        step();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wr_c%0d_pins", i + 1), pins(), wr_exp[i]);
            chk($sformatf("wr_c%0d_data", i + 1), {Mem_addr, Mem_wdata}, 32'h0040_1234);
            chk($sformatf("wr_c%0d_done", i + 1), Done, 1'b0);
            step();
        end
        chk("wr_done_pins", pins(), 4'b1110);
        chk("wr_done", Done, 1'b1);

        // LD_MDR during a read is ignored, flags Err, read data wins
        Mem_rdata = 16'h5A5A; Req_rd = 1'b1;
        step();
        clr_in(); Bus = 16'hFFFF; LD_MDR = 1'b1;
        step();
        clr_in(); Bus = '0;
        chk("col_err", Err, 1'b1);
        chk("col_mdr_hold", MDR, 16'h1234);
        step();
        chk("col_done_err", {Done, Err}, 2'b10);
        chk("col_mdr", MDR, 16'h5A5A);

        // Simultaneous read and write request: read performed, single Err
        Mem_rdata = 16'h7777; Req_rd = 1'b1; Req_wr = 1'b1;
        step();
        clr_in();
        chk("dual_c1_pins", pins(), 4'b0011);
        chk("dual_c1_err", Err, 1'b1);
        step();
        chk("dual_c2_err", {Err, Mem_WE_n}, 2'b01);
        step();
        chk("dual_done", {Done, Err}, 2'b10);
        chk("dual_mdr", MDR, 16'h7777);

        // Async reset in the middle of the write pulse
        Req_wr = 1'b1;
        step();
        clr_in();
        step();
        chk("mid_we_low", Mem_WE_n, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_pins", pins(), 4'b1110);
        chk("mid_rst_mar", MAR, 16'h0);
        step();
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("post_rst_%0d", i), {Done, Busy, Mem_WE_n, Mem_CE_n}, 4'b0011);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
